// File: rtl/hazard_pkg.sv
// Shared register-file geometry and producer latency codes for decode and the
// issue-side hazard scoreboard.
package hazard_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned LAT_W    = 3;

   // Stall cycles a consumer issued right behind the producer must wait
   localparam logic [LAT_W-1:0] LAT_ALU  = LAT_W'(0);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(1);
   localparam logic [LAT_W-1:0] LAT_MUL  = LAT_W'(3);

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue handshake between decode (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if;
   import hazard_pkg::*;

   logic             id_valid;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [REG_W-1:0] id_rd;
   logic             id_regwrite;
   logic [LAT_W-1:0] id_lat;
   logic             id_ready;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_regwrite, id_lat,
      input  id_ready
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_regwrite, id_lat,
      output id_ready
   );

endinterface

// File: rtl/hazard_scoreboard_sb_count_cell.sv
// One register's countdown until its in-flight result becomes forwardable.
module sb_count_cell
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt,
   output logic             busy
);

   // Flush beats a new producer; a new producer beats the running decrement
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - LAT_W'(1);
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side scoreboard: stalls ID until sources are forwardable and keeps
// variable-latency writebacks to the same register in order.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   hazard_scoreboard_if.slave   id,
   output logic [NUM_REGS-1:0]  busy_mask,
   output logic [CNT_W-1:0]     stall_cycles
);

   logic [LAT_W-1:0] cnt [NUM_REGS];
   logic             raw;
   logic             waw;
   logic             fire_wr;

   // Hazard checks use pre-update counters, so rd == rs never self-stalls
   always_comb begin
      raw = 1'b0;
      waw = 1'b0;
      if (id.id_rs1_used && (id.id_rs1 != '0) && (cnt[id.id_rs1] != '0)) raw = 1'b1;
      if (id.id_rs2_used && (id.id_rs2 != '0) && (cnt[id.id_rs2] != '0)) raw = 1'b1;
      if (id.id_regwrite && (id.id_rd != '0) && (cnt[id.id_rd] > id.id_lat)) waw = 1'b1;
   end

   assign id.id_ready = rst_n && !flush && !raw && !waw;
   assign fire_wr     = id.id_valid && id.id_ready && id.id_regwrite && (id.id_rd != '0);

   assign cnt[0]       = '0;
   assign busy_mask[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_cell
      sb_count_cell u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .load     (fire_wr && (id.id_rd == REG_W'(r))),
         .load_val (id.id_lat),
         .cnt      (cnt[r]),
         .busy     (busy_mask[r])
      );
   end

   // Saturating count of cycles an instruction sat at ID without issuing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (id.id_valid && !id.id_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side companion to the EX-stage forwarding unit. Forwarding only fixes hazards whose producer result already sits in EX/MEM or MEM/WB. This block tracks, per architectural register, how many cycles remain until an in-flight producer's result becomes forwardable. It stalls the ID stage until every source it needs can be forwarded or read, and it enforces in-order writeback (WAW) for variable-latency producers (ALU, load, multiply).

## Interface
Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hard-wired zero.
- REG_W, 5, register index width.
- LAT_W, 3, width of the producer latency field and of each countdown counter.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (branch mispredict/trap): cancels all pending tracking.
- id_valid  in  1  ID stage holds an instruction.
- id_rs1, id_rs2  in  REG_W  source indices.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd  in  REG_W  destination index.
- id_regwrite  in  1  instruction writes id_rd.
- id_lat  in  LAT_W  stall cycles a consumer issued right behind this producer needs (0 = ALU, 1 = load, 3 = mul).
- id_ready  out  1  instruction may issue this cycle. Fire = id_valid & id_ready.
- busy_mask  out  NUM_REGS  bit r = register r has a non-forwardable result pending.
- stall_cycles  out  CNT_W  saturating count of cycles with id_valid & !id_ready.

## Operation
- State: one countdown cnt[r] of width LAT_W per register r = 1..NUM_REGS-1. cnt[0] is constant 0.
- RAW stall: (id_rs1_used & id_rs1≠0 & cnt[id_rs1]≠0) | (id_rs2_used & id_rs2≠0 & cnt[id_rs2]≠0).
- WAW stall: id_regwrite & id_rd≠0 & cnt[id_rd] > id_lat. A shorter-latency writer must not overtake an older longer-latency writer.
- id_ready = !flush & !RAW & !WAW. It is combinational from current counters and ID inputs. id_ready does not depend on id_valid.
- Per-cycle counter update, highest priority first:
  - flush: all cnt ← 0.
  - Fire with id_regwrite & id_rd≠0: cnt[id_rd] ← id_lat.
  - Otherwise: cnt[r] ← cnt[r]−1 if nonzero. Counters never wrap below 0.
- Same cycle fire and decrement on the same register: the fire value wins.
- A fire whose rd equals one of its own sources does not self-stall. The check uses pre-update counters.
- busy_mask[r] = (cnt[r]≠0). busy_mask[0] is always 0.
- stall_cycles increments when id_valid & !id_ready, including flush cycles. It holds at 2^CNT_W−1. It is cleared only by reset.

## Timing
- Reset (rst_n low, asynchronous): all cnt = 0, busy_mask = 0, stall_cycles = 0.
- id_ready is forced 0 while rst_n is low. It follows the equation from the first cycle after deassertion.
- A producer fired in cycle t with lat L makes busy_mask[rd] high in cycles t+1 … t+L.
- A dependent consumer at ID therefore stalls exactly L cycles and fires in cycle t+L+1.
- L = 0 never sets busy and never stalls.
- flush in cycle t:
  - id_ready = 0 in cycle t, and no fire occurs.
  - busy_mask = 0 from cycle t+1.
- Reset asserted mid-stall: all state clears immediately. There is no pending-state recovery.

## Structure
- Shared package hazard_pkg holds:
  - NUM_REGS, REG_W, LAT_W.
  - Latency constants LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL = 3, so decode and this block agree.
- One natural sub-module, sb_count_cell: a single LAT_W countdown with load, flush and decrement, plus a busy output. It is instantiated NUM_REGS−1 times.
- Top level holds the source/destination comparison muxes, the ready logic and the perf counter.

## Test plan
- Load-use:
  - Stimulus: fire lw x5 (lat 1) at t, then present add x6,x5,x1 at t+1.
  - Response: id_ready = 0 at t+1, 1 at t+2; busy_mask[5] high only at t+1; stall_cycles = 1.
- ALU back-to-back:
  - Stimulus: add x3 (lat 0) then sub x4,x3,x3.
  - Response: no stall, busy_mask stays 0.
- Mul chain and WAW:
  - Stimulus: mul x7 (lat 3) at t; at t+1 present addi x7 (lat 0, no source use).
  - Response: stalls until cnt[7] = 0, fires at t+4.
  - Stimulus: in a separate sequence, present lw x7 (lat 1) when cnt[7] = 1.
  - Response: fires immediately.
- Flush during stall:
  - Stimulus: mul x9 at t, consumer of x9 waiting, flush at t+1.
  - Response: id_ready = 0 at t+1; busy_mask = 0 at t+2; consumer fires at t+2.
- x0 and unused sources:
  - Stimulus: producer writes x0 with lat 3; consumer reads x0, and a second consumer has rs2 = busy reg with rs2_used = 0.
  - Response: no busy bit, no stall.
- Reset and saturation:
  - Stimulus: assert rst_n low mid-stall; separately, hold a stall for 2^CNT_W+5 cycles.
  - Response: counters and stall_cycles go to 0 asynchronously; stall_cycles sticks at 0xFFFF.
